// File: rtl/alu_issue_sched_pkg.sv
// ---- alu_issue_sched_pkg : ALU op codes, scheduler states, latency-class decode (rev 1.0) ----
`default_nettype none

package alu_issue_sched_pkg;

  localparam logic [3:0] ALU_OP_ADD  = 4'd0;
  localparam logic [3:0] ALU_OP_SUB  = 4'd1;
  localparam logic [3:0] ALU_OP_AND  = 4'd2;
  localparam logic [3:0] ALU_OP_OR   = 4'd3;
  localparam logic [3:0] ALU_OP_XOR  = 4'd4;
  localparam logic [3:0] ALU_OP_SLT  = 4'd5;
  localparam logic [3:0] ALU_OP_SLTU = 4'd6;
  localparam logic [3:0] ALU_OP_SLL  = 4'd7;
  localparam logic [3:0] ALU_OP_SRA  = 4'd8;
  localparam logic [3:0] ALU_OP_SRL  = 4'd9;
  localparam logic [3:0] ALU_OP_MUL  = 4'd10;
  localparam logic [3:0] ALU_OP_DIV  = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } sched_state_t;

  typedef enum logic [1:0] {
    LAT_ONE = 2'd0,
    LAT_MUL = 2'd1,
    LAT_DIV = 2'd2
  } lat_class_t;

  // Unassigned codes 12-15 fall into the single-cycle class.
  function automatic lat_class_t lat_class(input logic [3:0] func);
    case (func)
      ALU_OP_MUL: return LAT_MUL;
      ALU_OP_DIV: return LAT_DIV;
      default:    return LAT_ONE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_issue_sched_if.sv
// ---- alu_issue_sched_if : request ports, ALU operand/result bus and CDB writeback (rev 1.0) ----
`default_nettype none

interface alu_issue_sched_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 6
);
  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_func;
  logic [WIDTH-1:0] req0_op1;
  logic [WIDTH-1:0] req0_op2;
  logic [TAG_W-1:0] req0_tag;

  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_func;
  logic [WIDTH-1:0] req1_op1;
  logic [WIDTH-1:0] req1_op2;
  logic [TAG_W-1:0] req1_tag;

  logic [3:0]       alu_func;
  logic [WIDTH-1:0] alu_op1;
  logic [WIDTH-1:0] alu_op2;
  logic [WIDTH-1:0] alu_out;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic [TAG_W-1:0] res_tag;

  modport slave (
    input  req0_valid, req0_func, req0_op1, req0_op2, req0_tag,
    input  req1_valid, req1_func, req1_op1, req1_op2, req1_tag,
    input  alu_out, res_ready,
    output req0_ready, req1_ready,
    output alu_func, alu_op1, alu_op2,
    output res_valid, res_data, res_tag
  );

  modport master (
    output req0_valid, req0_func, req0_op1, req0_op2, req0_tag,
    output req1_valid, req1_func, req1_op1, req1_op2, req1_tag,
    output alu_out, res_ready,
    input  req0_ready, req1_ready,
    input  alu_func, alu_op1, alu_op2,
    input  res_valid, res_data, res_tag
  );

endinterface

`default_nettype wire

// File: rtl/alu_issue_sched_rr_arb2.sv
// ---- rr_arb2 : two-input round-robin arbiter, pointer advances past each grant (rev 1.0) ----
`default_nettype none

module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic rr;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = rr ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)              rr <= 1'b0;
    else if (en && (|gnt))   rr <= gnt[0];
  end

endmodule

`default_nettype wire

// File: rtl/alu_issue_sched.sv
// ---- alu_issue_sched : round-robin issue into a shared ALU with multicycle operand hold (rev 1.0) ----
`default_nettype none

module alu_issue_sched
  import alu_issue_sched_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TAG_W   = 6,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  output logic               busy,
  alu_issue_sched_if.slave   bus
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  sched_state_t     state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       func_q;
  logic [WIDTH-1:0] op1_q;
  logic [WIDTH-1:0] op2_q;
  logic [TAG_W-1:0] tag_q;
  logic             res_valid_q;
  logic [WIDTH-1:0] res_data_q;
  logic [TAG_W-1:0] res_tag_q;

  logic             can_accept;
  logic [1:0]       gnt;
  logic             hs;
  logic [3:0]       sel_func;
  logic [WIDTH-1:0] sel_op1;
  logic [WIDTH-1:0] sel_op2;
  logic [TAG_W-1:0] sel_tag;
  logic [CNT_W-1:0] sel_lat_m1;

  assign can_accept = rst_n && !flush &&
                      ((state == ST_IDLE) || ((state == ST_RESP) && bus.res_ready));

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({bus.req1_valid, bus.req0_valid}),
    .en    (can_accept),
    .gnt   (gnt)
  );

  assign hs       = |gnt;
  assign sel_func = gnt[1] ? bus.req1_func : bus.req0_func;
  assign sel_op1  = gnt[1] ? bus.req1_op1  : bus.req0_op1;
  assign sel_op2  = gnt[1] ? bus.req1_op2  : bus.req0_op2;
  assign sel_tag  = gnt[1] ? bus.req1_tag  : bus.req0_tag;

  always_comb begin
    case (lat_class(sel_func))
      LAT_MUL: sel_lat_m1 = CNT_W'(MUL_LAT - 1);
      LAT_DIV: sel_lat_m1 = CNT_W'(DIV_LAT - 1);
      default: sel_lat_m1 = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      func_q      <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      tag_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
    end else if (flush) begin
      state       <= ST_IDLE;
      res_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hs) begin
            func_q <= sel_func;
            op1_q  <= sel_op1;
            op2_q  <= sel_op2;
            tag_q  <= sel_tag;
            cnt    <= sel_lat_m1;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            // Divide-by-zero is defined here rather than trusting the ALU.
            if ((func_q == ALU_OP_DIV) && (op2_q == '0)) res_data_q <= '1;
            else                                          res_data_q <= bus.alu_out;
            res_tag_q   <= tag_q;
            res_valid_q <= 1'b1;
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            if (hs) begin
              func_q <= sel_func;
              op1_q  <= sel_op1;
              op2_q  <= sel_op2;
              tag_q  <= sel_tag;
              cnt    <= sel_lat_m1;
              state  <= ST_EXEC;
            end else begin
              state  <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];
  assign bus.alu_func   = func_q;
  assign bus.alu_op1    = op1_q;
  assign bus.alu_op2    = op2_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_tag    = res_tag_q;
  assign busy           = (state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_sched.sv
// ---- tb_alu_issue_sched : directed self-checking bench with a behavioural ALU (rev 1.0) ----
`default_nettype none

module tb_alu_issue_sched;
  import alu_issue_sched_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic busy;
  int   n_checks = 0;
  int   n_pass   = 0;

  alu_issue_sched_if #(.WIDTH(32), .TAG_W(6)) bus ();

  alu_issue_sched #(.WIDTH(32), .TAG_W(6), .MUL_LAT(2), .DIV_LAT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ALU (funct7/funct3 tied off); divide by zero returns 0.
  logic [31:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (bus.alu_func)
      ALU_OP_ADD:  alu_res = bus.alu_op1 + bus.alu_op2;
      ALU_OP_SUB:  alu_res = bus.alu_op1 - bus.alu_op2;
      ALU_OP_AND:  alu_res = bus.alu_op1 & bus.alu_op2;
      ALU_OP_OR:   alu_res = bus.alu_op1 | bus.alu_op2;
      ALU_OP_XOR:  alu_res = bus.alu_op1 ^ bus.alu_op2;
      ALU_OP_SLT:  alu_res = {31'b0, $signed(bus.alu_op1) < $signed(bus.alu_op2)};
      ALU_OP_SLTU: alu_res = {31'b0, bus.alu_op1 < bus.alu_op2};
      ALU_OP_SLL:  alu_res = bus.alu_op1 << bus.alu_op2[4:0];
      ALU_OP_SRA:  alu_res = $signed(bus.alu_op1) >>> bus.alu_op2[4:0];
      ALU_OP_SRL:  alu_res = bus.alu_op1 >> bus.alu_op2[4:0];
      ALU_OP_MUL:  alu_res = bus.alu_op1 * bus.alu_op2;
      ALU_OP_DIV:  alu_res = (bus.alu_op2 == '0) ? '0 : bus.alu_op1 / bus.alu_op2;
      default:     alu_res = '0;
    endcase
  end
  assign bus.alu_out = alu_res;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic v, input logic [3:0] f,
                         input logic [31:0] a, input logic [31:0] b, input logic [5:0] t);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_func = f; bus.req0_op1 = a; bus.req0_op2 = b; bus.req0_tag = t;
    end else begin
      bus.req1_valid = v; bus.req1_func = f; bus.req1_op1 = a; bus.req1_op2 = b; bus.req1_tag = t;
    end
  endtask

  task automatic drop(input int p);
    if (p == 0) bus.req0_valid = 1'b0;
    else        bus.req1_valid = 1'b0;
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  // Present a request, wait (bounded) for the grant; returns in the first EXEC cycle.
  task automatic issue(input int p, input logic [3:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [5:0] t);
    int k;
    k = 0;
    set_req(p, 1'b1, f, a, b, t);
    #1;
    while (!rdy(p) && k < 50) begin
      tick();
      #1;
      k++;
    end
    chk("issue_grant", rdy(p), 1'b1);
    tick();
    drop(p);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 50) begin
      tick();
      k++;
    end
    chk("wait_idle", busy, 1'b0);
  endtask

  initial begin
    logic [5:0] t0, t1;
    logic       g0, g1, both, stable, hold, killed, seen;
    int         gq[$];
    int         tq[$];

    rst_n = 1'b0;
    flush = 1'b0;
    bus.res_ready = 1'b0;
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0, 6'd0);
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0, 6'd0);

    // Reset state; ready stays low while rst_n is low even with a valid request.
    tick(); tick();
    bus.req0_valid = 1'b1;
    #1;
    chk("rst_req0_ready", bus.req0_ready, 1'b0);
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_res_valid", bus.res_valid, 1'b0);
    chk("rst_res_data", bus.res_data, 32'd0);
    chk("rst_res_tag", bus.res_tag, 6'd0);
    chk("rst_alu_func", bus.alu_func, 4'd0);
    chk("rst_alu_op1", bus.alu_op1, 32'd0);
    chk("rst_alu_op2", bus.alu_op2, 32'd0);
    bus.req0_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Single ADD on port 0: 5 + 7, tag 3, result two cycles after handshake.
    bus.res_ready = 1'b1;
    set_req(0, 1'b1, ALU_OP_ADD, 32'd5, 32'd7, 6'd3);
    #1;
    chk("add_req0_ready", bus.req0_ready, 1'b1);
    chk("add_req1_ready", bus.req1_ready, 1'b0);
    tick();
    drop(0);
    chk("add_exec_busy", busy, 1'b1);
    chk("add_exec_op1", bus.alu_op1, 32'd5);
    chk("add_exec_op2", bus.alu_op2, 32'd7);
    chk("add_exec_nores", bus.res_valid, 1'b0);
    tick();
    chk("add_res_valid", bus.res_valid, 1'b1);
    chk("add_res_data", bus.res_data, 32'd12);
    chk("add_res_tag", bus.res_tag, 6'd3);
    tick();
    chk("add_after_valid", bus.res_valid, 1'b0);
    chk("add_after_busy", busy, 1'b0);

    // One port-1 op so the pointer prefers port 0 next: SUB 9 - 4 = 5.
    issue(1, ALU_OP_SUB, 32'd9, 32'd4, 6'd1);
    tick();
    chk("sub_res_data", bus.res_data, 32'd5);
    wait_idle();

    // Both ports valid every cycle: grants alternate starting with port 0.
    t0 = 6'd10; t1 = 6'd20; both = 1'b0;
    set_req(0, 1'b1, ALU_OP_ADD, 32'd1, 32'd1, t0);
    set_req(1, 1'b1, ALU_OP_ADD, 32'd2, 32'd2, t1);
    for (int i = 0; i < 9; i++) begin
      #1;
      g0 = rdy(0);
      g1 = rdy(1);
      if (g0 && g1) both = 1'b1;
      if (g0) gq.push_back(0);
      if (g1) gq.push_back(1);
      if (bus.res_valid) tq.push_back(int'(bus.res_tag));
      tick();
      if (g0) begin t0++; set_req(0, 1'b1, ALU_OP_ADD, 32'd1, 32'd1, t0); end
      if (g1) begin t1++; set_req(1, 1'b1, ALU_OP_ADD, 32'd2, 32'd2, t1); end
    end
    drop(0); drop(1);
    wait_idle();
    chk("rr_both_ready", both, 1'b0);
    chk("rr_gnt0", (gq.size() > 0) ? gq[0] : 9, 0);
    chk("rr_gnt1", (gq.size() > 1) ? gq[1] : 9, 1);
    chk("rr_gnt2", (gq.size() > 2) ? gq[2] : 9, 0);
    chk("rr_gnt3", (gq.size() > 3) ? gq[3] : 9, 1);
    chk("rr_tag0", (tq.size() > 0) ? tq[0] : 99, 10);
    chk("rr_tag1", (tq.size() > 1) ? tq[1] : 99, 20);
    chk("rr_tag2", (tq.size() > 2) ? tq[2] : 99, 11);
    chk("rr_tag3", (tq.size() > 3) ? tq[3] : 99, 21);

    // MUL 6 x 7: operands held for 2 EXEC cycles, result in c+3.
    issue(0, ALU_OP_MUL, 32'd6, 32'd7, 6'd30);
    stable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (bus.alu_op1 != 32'd6 || bus.alu_op2 != 32'd7 || bus.alu_func != ALU_OP_MUL || bus.res_valid)
        stable = 1'b0;
      tick();
    end
    chk("mul_stable", stable, 1'b1);
    chk("mul_res_valid", bus.res_valid, 1'b1);
    chk("mul_res_data", bus.res_data, 32'd42);
    chk("mul_res_tag", bus.res_tag, 6'd30);
    tick();

    // DIV 100 / 7: operands held for 8 EXEC cycles, result in c+9.
    issue(0, ALU_OP_DIV, 32'd100, 32'd7, 6'd31);
    stable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (bus.alu_op1 != 32'd100 || bus.alu_op2 != 32'd7 || bus.res_valid) stable = 1'b0;
      tick();
    end
    chk("div_stable", stable, 1'b1);
    chk("div_res_valid", bus.res_valid, 1'b1);
    chk("div_res_data", bus.res_data, 32'd14);
    tick();

    // DIV 9 / 0 returns all ones.
    issue(1, ALU_OP_DIV, 32'd9, 32'd0, 6'd32);
    for (int i = 0; i < 8; i++) tick();
    chk("div0_res_valid", bus.res_valid, 1'b1);
    chk("div0_res_data", bus.res_data, 32'hFFFF_FFFF);
    chk("div0_res_tag", bus.res_tag, 6'd32);
    tick();
    chk("div0_idle", busy, 1'b0);

    // Writeback stall: result held while port 1 waits, then accepted back-to-back.
    bus.res_ready = 1'b0;
    issue(0, ALU_OP_ADD, 32'd3, 32'd4, 6'd5);
    set_req(1, 1'b1, ALU_OP_ADD, 32'd10, 32'd20, 6'd7);
    #1;
    chk("exec_no_grant", rdy(1), 1'b0);
    tick();
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (!bus.res_valid || bus.res_data != 32'd7 || bus.res_tag != 6'd5 || rdy(0) || rdy(1))
        hold = 1'b0;
      tick();
    end
    chk("stall_hold", hold, 1'b1);
    bus.res_ready = 1'b1;
    #1;
    chk("stall_same_cycle_grant", rdy(1), 1'b1);
    chk("stall_res_valid", bus.res_valid, 1'b1);
    tick();
    drop(1);
    chk("b2b_res_cleared", bus.res_valid, 1'b0);
    chk("b2b_busy", busy, 1'b1);
    chk("b2b_op1", bus.alu_op1, 32'd10);
    tick();
    chk("b2b_res_valid", bus.res_valid, 1'b1);
    chk("b2b_res_data", bus.res_data, 32'd30);
    chk("b2b_res_tag", bus.res_tag, 6'd7);
    tick();
    chk("b2b_idle", busy, 1'b0);

    // Flush in the middle of a DIV: no result for tag 9, grant in the following cycle.
    issue(0, ALU_OP_DIV, 32'd50, 32'd5, 6'd9);
    tick(); tick(); tick();
    flush = 1'b1;
    set_req(1, 1'b1, ALU_OP_ADD, 32'd1, 32'd2, 6'd11);
    #1;
    chk("flush_no_grant", rdy(1), 1'b0);
    tick();
    flush = 1'b0;
    chk("flush_res_valid", bus.res_valid, 1'b0);
    chk("flush_busy", busy, 1'b0);
    chk("flush_op_kept", bus.alu_op1, 32'd50);
    #1;
    chk("flush_next_grant", rdy(1), 1'b1);
    tick();
    drop(1);
    killed = 1'b0; seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus.res_valid && bus.res_tag == 6'd9) killed = 1'b1;
      if (bus.res_valid && bus.res_tag == 6'd11 && bus.res_data == 32'd3) seen = 1'b1;
      tick();
    end
    chk("flush_killed_tag", killed, 1'b0);
    chk("flush_new_result", seen, 1'b1);

    // Reset while holding a result in RESP.
    bus.res_ready = 1'b0;
    issue(1, ALU_OP_ADD, 32'd4, 32'd4, 6'd13);
    tick();
    chk("rresp_valid", bus.res_valid, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rresp_res_valid", bus.res_valid, 1'b0);
    chk("rresp_busy", busy, 1'b0);
    chk("rresp_res_tag", bus.res_tag, 6'd0);
    chk("rresp_alu_op1", bus.alu_op1, 32'd0);
    bus.res_ready = 1'b1;
    set_req(0, 1'b1, ALU_OP_XOR, 32'hF0, 32'h0F, 6'd14);
    #1;
    chk("rresp_next_grant", rdy(0), 1'b1);
    tick();
    drop(0);
    tick();
    chk("rresp_new_data", bus.res_data, 32'hFF);
    chk("rresp_new_tag", bus.res_tag, 6'd14);
    tick();
    chk("rresp_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/alu_issue_sched.md
# alu_issue_sched

Issue scheduler for the shared integer ALU. Arbitrates round-robin between two reservation-station ports and drives the combinational ALU from stable operand registers. Holds those operands for the op's latency class: 1 cycle for logic/arith, MUL_LAT for MUL, DIV_LAT for DIV (multicycle paths). It then returns the tagged result on a valid/ready writeback port to the CDB.

## Interface
- WIDTH, 32, operand/result width
- TAG_W, 6, ROB tag width
- MUL_LAT, 2, cycles ALU inputs held for MUL (>=1)
- DIV_LAT, 8, cycles ALU inputs held for DIV (>=1)

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- flush  in  1  synchronous kill of in-flight op and pending result
- req0_valid / req1_valid  in  1  request valid per port
- req0_ready / req1_ready  out  1  grant; handshake = valid && ready
- req0_func / req1_func  in  4  ALU_OP_* code
- req0_op1, req0_op2 / req1_op1, req1_op2  in  WIDTH  operands
- req0_tag / req1_tag  in  TAG_W  ROB tag
- alu_func  out  4  to ALU, from op register
- alu_op1, alu_op2  out  WIDTH  to ALU, from op registers
- alu_out  in  WIDTH  ALU result
- res_valid  out  1  result valid
- res_ready  in  1  CDB accepts
- res_data  out  WIDTH  result
- res_tag  out  TAG_W  tag of result
- busy  out  1  state != IDLE

## Operation
- States: IDLE, EXEC, RESP.
- can_accept = !flush && (IDLE || (RESP && res_ready)).
- Arbitration: rr pointer selects the preferred port.
  - Both valid: grant port rr.
  - One valid: grant that port.
  - After any grant, rr <= other port.
  - At most one reqN_ready is high, and only when can_accept.
  - ready may depend combinationally on valid. Requesters hold valid and payload until handshake.
- On handshake, load func/op1/op2/tag registers. Go to EXEC with cnt = latency-1.
  - Latency: ADD/SUB/AND/OR/XOR/SLT/SLTU/SLL/SRA/SRL = 1; MUL = MUL_LAT; DIV = DIV_LAT.
  - Codes 12–15 are 1-cycle and produce whatever the ALU returns (0).
- EXEC:
  - Op registers are unchanged throughout; alu_* outputs equal them at all times.
  - cnt != 0: decrement.
  - cnt == 0: res_data <= alu_out, res_tag <= tag, res_valid <= 1, go to RESP.
  - DIV with op2 == 0: res_data <= all-ones and alu_out is ignored.
- RESP: res_valid held high with stable data until res_ready.
  - res_ready with a new handshake in the same cycle: go to EXEC (back-to-back).
  - res_ready without a handshake: go to IDLE and clear res_valid.
- flush: highest priority. Next state IDLE, res_valid <= 0, no grant that cycle, rr unchanged. Op registers keep their values.
- Reset (rst_n low at edge):
  - State IDLE, rr = 0, cnt = 0, res_valid = 0, res_data = 0, res_tag = 0.
  - Op registers = 0, so alu_func/op1/op2 = 0.
  - busy = 0; req ready = 0 while rst_n low.

## Timing
- Handshake in cycle c gives EXEC in cycles c+1 … c+L and res_valid high from cycle c+L+1, where L is the latency.
  - 1-cycle op: res_valid in c+2.
  - MUL with MUL_LAT = 2: res_valid in c+3.
- Throughput with res_ready held high: one op per L+1 cycles. The accept in the RESP cycle overlaps the writeback.
- No new request is accepted in EXEC; both readies are low.
- flush in cycle f: res_valid low from f+1; first possible grant in f+1.
- rst_n and flush asserted together behave as reset.

## Structure
- Shared header/package alu_defs:
  - ALU_OP_* codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRA 8, SRL 9, MUL 10, DIV 11.
  - Scheduler state encoding.
  - Latency-class decode function.
- One sub-module, rr_arb2: 2-input round-robin arbiter. Inputs req[1:0], en; outputs gnt[1:0]; owns the rr register, which updates only when en && |gnt.
- The ALU instance sits at the parent level. funct7/funct3 are tied to 0 there.

## Test plan
- Reset, then a single ADD on port 0 (op1 = 5, op2 = 7, tag 3) with res_ready = 1 → res_valid two cycles after handshake, res_data = 12, res_tag = 3, busy low afterwards.
- Both ports valid every cycle, all ADDs → grants alternate 0,1,0,1. Tags appear in that order. No cycle has both readies high.
- MUL 6×7 with MUL_LAT = 2, then DIV 100/7 with DIV_LAT = 8 → alu_op1/op2 stable for 2 and 8 EXEC cycles. Results 42 and 14 at c+3 and c+9.
- DIV 9/0 → res_data = 0xFFFFFFFF.
- res_ready low for 5 cycles while port 1 is valid → res_valid/data/tag held, req1_ready low. On res_ready = 1, the new request is accepted in the same cycle.
- flush in the middle of a DIV, and separately reset in RESP → res_valid low next cycle, no result for the killed tag, state IDLE, next request granted in the following cycle.
